// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-channel data memory with per-channel valid/ready
// responder FSMs sharing one storage array, a backdoor load port and
// saturating read/write activity counters.
module data_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int LATENCY   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            read_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]            read_ready,
  output logic [CHANNELS*DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]            write_valid,
  input  logic [CHANNELS*ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS*DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]            write_ready,
  input  logic                           load_enable,
  input  logic [ADDR_BITS-1:0]           load_address,
  input  logic [DATA_BITS-1:0]           load_data,
  output logic [15:0]                    read_count,
  output logic [15:0]                    write_count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Countdown preset at acceptance; zero means the next edge completes.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_RD = 3'd1,
    ST_WAIT_WR = 3'd2,
    ST_DONE_RD = 3'd3,
    ST_DONE_WR = 3'd4
  } state_t;

  // Shared storage; deliberately not cleared by reset.
  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t               state_q [CHANNELS];
  state_t               state_d [CHANNELS];
  logic [3:0]           cnt_q   [CHANNELS];
  logic [3:0]           cnt_d   [CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [CHANNELS];
  logic [DATA_BITS-1:0] wdata_q [CHANNELS];
  logic [DATA_BITS-1:0] wdata_d [CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [CHANNELS];
  logic [DATA_BITS-1:0] rdata_d [CHANNELS];

  logic [CHANNELS-1:0]  rd_accept;
  logic [CHANNELS-1:0]  rd_capture;
  logic [CHANNELS-1:0]  wr_commit;

  logic [15:0]          read_count_q;
  logic [15:0]          read_count_d;
  logic [15:0]          write_count_q;
  logic [15:0]          write_count_d;
  logic [16:0]          rd_sum;
  logic [16:0]          wr_sum;

  // State register: FSM state is the only per-channel control cleared by reset.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (reset) begin
        state_q[ch] <= ST_IDLE;
      end else begin
        state_q[ch] <= state_d[ch];
      end
    end
  end

  // Per-channel datapath registers: countdown, latched request, captured read data.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cnt_q[ch]   <= cnt_d[ch];
      addr_q[ch]  <= addr_d[ch];
      wdata_q[ch] <= wdata_d[ch];
      if (reset) begin
        rdata_q[ch] <= '0;
      end else begin
        rdata_q[ch] <= rdata_d[ch];
      end
    end
  end

  // Next-state logic: acceptance, countdown, abort, completion and handshake release.
  always_comb begin
    rd_accept  = '0;
    rd_capture = '0;
    wr_commit  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      addr_d[ch]  = addr_q[ch];
      wdata_d[ch] = wdata_q[ch];
      rdata_d[ch] = rdata_q[ch];
      case (state_q[ch])
        ST_IDLE: begin
          // Read wins a simultaneous request; the write stays pending on its valid.
          if (read_valid[ch]) begin
            state_d[ch]   = ST_WAIT_RD;
            addr_d[ch]    = read_address[ch*ADDR_BITS +: ADDR_BITS];
            cnt_d[ch]     = CNT_INIT;
            rd_accept[ch] = 1'b1;
          end else if (write_valid[ch]) begin
            state_d[ch] = ST_WAIT_WR;
            addr_d[ch]  = write_address[ch*ADDR_BITS +: ADDR_BITS];
            wdata_d[ch] = write_data[ch*DATA_BITS +: DATA_BITS];
            cnt_d[ch]   = CNT_INIT;
          end
        end
        ST_WAIT_RD: begin
          if (!read_valid[ch]) begin
            state_d[ch] = ST_IDLE;
          end else if (cnt_q[ch] != 4'd0) begin
            cnt_d[ch] = cnt_q[ch] - 4'd1;
          end else begin
            // Storage is written non-blocking, so this sees pre-edge contents.
            state_d[ch]    = ST_DONE_RD;
            rdata_d[ch]    = mem[addr_q[ch]];
            rd_capture[ch] = 1'b1;
          end
        end
        ST_WAIT_WR: begin
          if (!write_valid[ch]) begin
            state_d[ch] = ST_IDLE;
          end else if (cnt_q[ch] != 4'd0) begin
            cnt_d[ch] = cnt_q[ch] - 4'd1;
          end else begin
            state_d[ch]   = ST_DONE_WR;
            wr_commit[ch] = 1'b1;
          end
        end
        ST_DONE_RD: begin
          if (!read_valid[ch]) begin
            state_d[ch] = ST_IDLE;
          end
        end
        ST_DONE_WR: begin
          if (!write_valid[ch]) begin
            state_d[ch] = ST_IDLE;
          end
        end
        default: begin
          state_d[ch] = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: ready is a pure function of the registered state.
  always_comb begin
    read_ready  = '0;
    write_ready = '0;
    read_data   = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      read_ready[ch]  = (state_q[ch] == ST_DONE_RD);
      write_ready[ch] = (state_q[ch] == ST_DONE_WR);
      read_data[ch*DATA_BITS +: DATA_BITS] = rdata_q[ch];
    end
  end

  // Storage writes: ascending channel order so the highest index wins a collision,
  // then the backdoor load last so it beats any channel; commits are dropped under reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (wr_commit[ch]) begin
          mem[addr_q[ch]] <= wdata_q[ch];
        end
      end
    end
    if (load_enable) begin
      mem[load_address] <= load_data;
    end
  end

  // Counter next state: sum all channel events of this edge, then clamp.
  always_comb begin
    rd_sum = {1'b0, read_count_q};
    wr_sum = {1'b0, write_count_q};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      rd_sum = rd_sum + {16'd0, rd_accept[ch]};
      wr_sum = wr_sum + {16'd0, wr_commit[ch]};
    end
    read_count_d  = rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
    write_count_d = wr_sum[16] ? 16'hFFFF : wr_sum[15:0];
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// multi-channel batches compared against an array-based reference memory.
module tb_data_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int CH  = 4;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     read_valid;
  logic [CH*AB-1:0]  read_address;
  logic [CH-1:0]     read_ready;
  logic [CH*DB-1:0]  read_data;
  logic [CH-1:0]     write_valid;
  logic [CH*AB-1:0]  write_address;
  logic [CH*DB-1:0]  write_data;
  logic [CH-1:0]     write_ready;
  logic              load_enable;
  logic [AB-1:0]     load_address;
  logic [DB-1:0]     load_data;
  logic [15:0]       read_count;
  logic [15:0]       write_count;

  data_mem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address),
    .write_data(write_data), .write_ready(write_ready),
    .load_enable(load_enable), .load_address(load_address), .load_data(load_data),
    .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DB-1:0] ref_mem  [256];
  logic [DB-1:0] ref_last [CH];
  int            ref_rc;
  int            ref_wc;

  // Batch description
  int            b_op    [CH];   // 0 none, 1 read, 2 write
  logic [AB-1:0] b_addr  [CH];
  logic [DB-1:0] b_data  [CH];
  bit            b_abort [CH];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] sat(input int v);
    return (v > 65535) ? 32'd65535 : 32'(v);
  endfunction

  function automatic logic [CH*DB-1:0] packed_last();
    logic [CH*DB-1:0] p;
    for (int c = 0; c < CH; c++) p[c*DB +: DB] = ref_last[c];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_batch();
    for (int c = 0; c < CH; c++) begin
      b_op[c] = 0; b_addr[c] = '0; b_data[c] = '0; b_abort[c] = 1'b0;
    end
  endtask

  // All selected channels request on the same edge; every capture and commit then
  // lands on one edge, so reads see pre-batch memory and writes apply in channel order.
  task automatic run_batch();
    logic [CH-1:0] exp_rr;
    logic [CH-1:0] exp_wr;
    int nrd;
    int nwr;
    exp_rr = '0; exp_wr = '0; nrd = 0; nwr = 0;
    for (int c = 0; c < CH; c++) begin
      if (b_op[c] == 1) begin
        exp_rr[c] = 1'b1; nrd++;
        ref_last[c] = ref_mem[b_addr[c]];
      end
      if (b_op[c] == 2 && !b_abort[c]) begin
        exp_wr[c] = 1'b1; nwr++;
      end
      read_valid[c]  = (b_op[c] == 1);
      write_valid[c] = (b_op[c] == 2);
      read_address[c*AB +: AB]  = b_addr[c];
      write_address[c*AB +: AB] = b_addr[c];
      write_data[c*DB +: DB]    = b_data[c];
    end
    tick();
    ref_rc += nrd;
    check("rd_cnt_accept", 32'(read_count), sat(ref_rc));
    for (int c = 0; c < CH; c++) if (b_abort[c]) write_valid[c] = 1'b0;
    repeat (LAT - 1) tick();
    check("ready_early", 32'({read_ready, write_ready}), 32'd0);
    tick();
    check("read_ready", 32'(read_ready), 32'(exp_rr));
    check("write_ready", 32'(write_ready), 32'(exp_wr));
    check("read_data", 32'(read_data), 32'(packed_last()));
    for (int c = 0; c < CH; c++) if (exp_wr[c]) ref_mem[b_addr[c]] = b_data[c];
    ref_wc += nwr;
    check("wr_cnt_commit", 32'(write_count), sat(ref_wc));
    tick();
    check("ready_hold", 32'({read_ready, write_ready}), 32'({exp_rr, exp_wr}));
    read_valid = '0; write_valid = '0;
    tick();
    check("ready_drop", 32'({read_ready, write_ready}), 32'd0);
    check("rdata_hold", 32'(read_data), 32'(packed_last()));
  endtask

  task automatic read_back(input int base);
    clear_batch();
    for (int c = 0; c < CH; c++) begin
      b_op[c] = 1; b_addr[c] = AB'(base + c);
    end
    run_batch();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    read_valid = '0; read_address = '0; write_valid = '0;
    write_address = '0; write_data = '0;
    load_enable = 1'b0; load_address = '0; load_data = '0;
    ref_rc = 0; ref_wc = 0;
    for (int c = 0; c < CH; c++) ref_last[c] = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
    tick();

    // Backdoor preload while reset is held
    for (int i = 0; i < 64; i++) begin
      load_enable  = 1'b1;
      load_address = AB'(i);
      load_data    = (i < 16) ? DB'(i % 8) : DB'($urandom);
      ref_mem[i]   = load_data;
      tick();
    end
    load_enable = 1'b0;
    check("rst_read_ready", 32'(read_ready), 32'd0);
    check("rst_write_ready", 32'(write_ready), 32'd0);
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_read_count", 32'(read_count), 32'd0);
    check("rst_write_count", 32'(write_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single read, ch0 addr 5
    clear_batch(); b_op[0] = 1; b_addr[0] = 8'd5; run_batch();
    check("t1_data", 32'(read_data[7:0]), 32'd5);

    // Write then read back through a different channel
    clear_batch(); b_op[2] = 2; b_addr[2] = 8'd16; b_data[2] = 8'd14; run_batch();
    clear_batch(); b_op[1] = 1; b_addr[1] = 8'd16; run_batch();
    check("t2_data", 32'(read_data[15:8]), 32'd14);

    // Same-edge collision: highest channel wins
    clear_batch();
    b_op[0] = 2; b_addr[0] = 8'd20; b_data[0] = 8'hAA;
    b_op[3] = 2; b_addr[3] = 8'd20; b_data[3] = 8'h55;
    run_batch();
    clear_batch(); b_op[2] = 1; b_addr[2] = 8'd20; run_batch();
    check("t3_data", 32'(read_data[23:16]), 32'h55);

    // Aborted write leaves memory and write_count alone
    clear_batch(); b_op[1] = 2; b_addr[1] = 8'd24; b_data[1] = 8'h3C; b_abort[1] = 1'b1;
    run_batch();
    clear_batch(); b_op[1] = 1; b_addr[1] = 8'd24; run_batch();

    // Read and write together on ch0: read first, write after read_valid drops
    read_valid[0] = 1'b1; write_valid[0] = 1'b1;
    read_address[7:0] = 8'd3; write_address[7:0] = 8'd40; write_data[7:0] = 8'h77;
    tick();
    ref_rc++;
    check("rw_rd_cnt", 32'(read_count), sat(ref_rc));
    repeat (LAT - 1) tick();
    check("rw_early", 32'({read_ready, write_ready}), 32'd0);
    tick();
    ref_last[0] = ref_mem[3];
    check("rw_rd_ready", 32'({read_ready, write_ready}), 32'h10);
    check("rw_rd_data", 32'(read_data[7:0]), 32'(ref_last[0]));
    read_valid[0] = 1'b0;
    tick();
    check("rw_release", 32'({read_ready, write_ready}), 32'd0);
    tick();
    repeat (LAT - 1) tick();
    check("rw_wr_early", 32'(write_ready), 32'd0);
    tick();
    check("rw_wr_ready", 32'(write_ready), 32'h1);
    ref_mem[40] = 8'h77; ref_wc++;
    check("rw_wr_cnt", 32'(write_count), sat(ref_wc));
    write_valid[0] = 1'b0;
    tick();
    check("rw_wr_drop", 32'(write_ready), 32'd0);

    // Backdoor load beats a commit; inputs after acceptance are ignored
    write_valid[1] = 1'b1; write_address[15:8] = 8'd30; write_data[15:8] = 8'h11;
    write_valid[2] = 1'b1; write_address[23:16] = 8'd31; write_data[23:16] = 8'h44;
    tick();
    write_address[23:16] = 8'd32; write_data[23:16] = 8'h66;
    repeat (LAT - 1) tick();
    load_enable = 1'b1; load_address = 8'd30; load_data = 8'h99;
    tick();
    load_enable = 1'b0;
    check("ld_wr_ready", 32'(write_ready), 32'h6);
    ref_mem[30] = 8'h99; ref_mem[31] = 8'h44; ref_wc += 2;
    check("ld_wr_cnt", 32'(write_count), sat(ref_wc));
    write_valid = '0;
    tick();

    // Randomized multi-channel batches over a small address window
    for (int n = 0; n < 60; n++) begin
      clear_batch();
      for (int c = 0; c < CH; c++) begin
        b_op[c]    = int'($urandom_range(0, 2));
        b_addr[c]  = AB'($urandom_range(0, 7));
        b_data[c]  = DB'($urandom);
        b_abort[c] = (b_op[c] == 2) && ($urandom_range(0, 3) == 0);
      end
      run_batch();
    end

    // Reset mid-operation: one channel in DONE, one write still pending
    read_valid[1] = 1'b1; read_address[15:8] = 8'd2;
    tick();
    tick();
    write_valid[2] = 1'b1; write_address[23:16] = 8'd50; write_data[23:16] = 8'hEE;
    tick();
    tick();
    check("mid_rd_ready", 32'(read_ready), 32'h2);
    reset = 1'b1; read_valid = '0; write_valid = '0;
    tick();
    check("mid_rst_ready", 32'({read_ready, write_ready}), 32'd0);
    check("mid_rst_rdata", 32'(read_data), 32'd0);
    check("mid_rst_rcnt", 32'(read_count), 32'd0);
    check("mid_rst_wcnt", 32'(write_count), 32'd0);
    reset = 1'b0;
    ref_rc = 0; ref_wc = 0;
    for (int c = 0; c < CH; c++) ref_last[c] = '0;
    repeat (LAT + 1) tick();
    check("mid_post_wcnt", 32'(write_count), 32'd0);

    // Full read-back of the preloaded window
    for (int base = 0; base < 64; base += CH) read_back(base);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
